// File: rtl/m_imem_loader_pkg.sv
// Shared types and frame constants for the boot-time instruction memory loader.
`timescale 1ns/1ps
package m_imem_loader_pkg;

  localparam int unsigned LEN_BYTES      = 4;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BIDX_W         = 2;

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_SUM  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } imem_wr_t;

  // Byte address of a word slot relative to the image base.
  function automatic logic [WORD_W-1:0] word_addr(input logic [WORD_W-1:0] base,
                                                  input logic [WORD_W-1:0] idx);
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/m_byte_pack.sv
// Little-endian 4-byte assembler: first byte lands in [7:0], the fourth completes the word.
`timescale 1ns/1ps
module m_byte_pack
  import m_imem_loader_pkg::*;
(
  input  logic                w_clk,
  input  logic                w_rst_n,
  input  logic                w_en,
  input  logic [BYTE_W-1:0]   w_byte,
  output logic [WORD_W-1:0]   w_word_c,
  output logic                w_last_c
);

  localparam int unsigned BUF_W = WORD_W - BYTE_W;

  logic [BIDX_W-1:0] idx_q;
  logic [BUF_W-1:0]  buf_q;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      idx_q <= '0;
      buf_q <= '0;
    end else if (w_en) begin
      idx_q <= idx_q + BIDX_W'(1);
      case (idx_q)
        2'd0:    buf_q[7:0]   <= w_byte;
        2'd1:    buf_q[15:8]  <= w_byte;
        2'd2:    buf_q[23:16] <= w_byte;
        default: ;
      endcase
    end
  end

  // The top byte is taken straight from the input so the word is ready on the completing transfer.
  assign w_word_c = {w_byte, buf_q};
  assign w_last_c = w_en && (idx_q == BIDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/m_imem_loader.sv
// Boot loader: parses a length/payload/checksum byte frame into imem writes and releases the core on success.
`timescale 1ns/1ps
module m_imem_loader
  import m_imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  input  logic        w_in_valid,
  input  logic [7:0]  w_in_data,
  output logic        w_in_ready,
  output logic        w_we,
  output logic [31:0] w_waddr,
  output logic [31:0] w_wdata,
  output logic        w_done,
  output logic        w_err,
  output logic        w_cpu_rst_n
);

  localparam int unsigned IDX_W = $clog2(MAX_WORDS + 1);

  state_e            state_q;
  logic [WORD_W-1:0] len_q;
  logic [IDX_W-1:0]  widx_q;
  logic [BYTE_W-1:0] sum_q;
  imem_wr_t          wr_q;
  logic              we_q;
  logic              done_q;
  logic              err_q;
  logic              cpu_rst_n_q;

  logic              accept_c;
  logic              pack_en_c;
  logic [WORD_W-1:0] word_c;
  logic              last_c;
  logic              last_word_c;

  assign w_in_ready  = w_rst_n & (state_q inside {S_LEN, S_DATA, S_SUM});
  assign accept_c    = w_in_valid & w_in_ready;
  assign pack_en_c   = accept_c & ((state_q == S_LEN) | (state_q == S_DATA));
  assign last_word_c = (WORD_W'(widx_q) == (len_q - WORD_W'(1)));

  // Length field and payload words share one assembler since both are 4-byte little-endian.
  m_byte_pack u_pack (
    .w_clk    (w_clk),
    .w_rst_n  (w_rst_n),
    .w_en     (pack_en_c),
    .w_byte   (w_in_data),
    .w_word_c (word_c),
    .w_last_c (last_c)
  );

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q     <= S_LEN;
      len_q       <= '0;
      widx_q      <= '0;
      sum_q       <= '0;
      wr_q        <= '0;
      we_q        <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_LEN: begin
          if (accept_c) begin
            sum_q <= sum_q ^ w_in_data;
            if (last_c) begin
              len_q <= word_c;
              if (word_c > WORD_W'(MAX_WORDS)) begin
                state_q <= S_ERR;
                err_q   <= 1'b1;
              end else if (word_c == '0) begin
                state_q <= S_SUM;
              end else begin
                state_q <= S_DATA;
              end
            end
          end
        end
        S_DATA: begin
          if (accept_c) begin
            sum_q <= sum_q ^ w_in_data;
            if (last_c) begin
              we_q      <= 1'b1;
              wr_q.addr <= word_addr(BASE_ADDR, WORD_W'(widx_q));
              wr_q.data <= word_c;
              widx_q    <= widx_q + IDX_W'(1);
              if (last_word_c) state_q <= S_SUM;
            end
          end
        end
        S_SUM: begin
          // The checksum byte is compared, never folded into the running XOR.
          if (accept_c) begin
            if (w_in_data == sum_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_rst_n_q <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign w_we        = we_q;
  assign w_waddr     = wr_q.addr;
  assign w_wdata     = wr_q.data;
  assign w_done      = done_q;
  assign w_err       = err_q;
  assign w_cpu_rst_n = cpu_rst_n_q;

endmodule
